dt_pack: RTL and testbench
==========================

# dt_pack

Post-processing block for the distance-transform datapath. It reads the 128x128 8-bit distance map from the result RAM and thresholds each pixel against a programmable level. It then packs the 1-bit results MSB-first into 16-bit words and writes them to a 1024-word binary image memory, which is the layout the transform consumes. It also reports the count of set pixels, so an eroded or thresholded mask can be fed back to the transform or checked by the host.

## Interface
Parameters:
- none; image fixed at 128x128, 16 pixels per word.

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-low; one clock, reset asynchronous and active-low.
- start  in  1  one-cycle pulse in IDLE or DONE starts a pass; ignored while busy.
- thr  in  8  threshold, sampled on the start edge; pixel = (res_di >= thr).
- res_rd  out  1  read strobe to distance RAM.
- res_addr  out  14  {y[6:0], x[6:0]} read address, registered.
- res_di  in  8  read data; valid while res_addr is held (combinational-read RAM), sampled on the next rising edge.
- sti_wr  out  1  write strobe to binary image memory, one cycle per word.
- sti_addr  out  10  {y[6:0], w[2:0]} word address, registered.
- sti_do  out  16  packed word; bit 15-i is pixel x = 8*0+16*w+i.
- fg_count  out  15  number of set pixels in the last pass (0..16384); valid when done=1.
- busy  out  1  high from the start edge until done rises.
- done  out  1  level, high from pass completion until the next accepted start.

## Operation
- Reset values:
  - Outputs: res_rd=0, res_addr=0, sti_wr=0, sti_addr=0, sti_do=0, fg_count=0, busy=0, done=0.
  - Internal: state=IDLE, thr_q=0, bit counter=0, shift register=0.
- States:
  - IDLE: waits for start. On start: latch thr_q, clear fg_count and done, set res_addr=0, res_rd=1, busy=1, bit=0, then go to READ.
  - READ: each edge shifts (res_di >= thr_q) into the LSB of a 16-bit shift register and adds it to fg_count. res_addr increments by 1 each edge. On bit==15 the edge goes to WRITE instead, and res_addr still increments.
  - WRITE: one cycle. sti_do holds the completed word, sti_wr=1, and sti_addr is the index of the word just packed. res_rd=0 and res_addr holds the next pixel. Next edge:
    - If the word index was 1023, go to DONE.
    - Otherwise go to READ with res_rd=1 and bit=0.
  - DONE: sti_wr=0, res_rd=0, busy=0, done=1. A start here behaves as from IDLE.
- Arithmetic:
  - Comparison is unsigned 8-bit.
  - thr=0 makes every pixel set.
  - thr=255 sets only pixels with res_di=255.
- Addressing:
  - res_addr is 14-bit linear, so x rolls 127 to 0 and y increments.
  - After the final pixel, res_addr wraps 16383 to 0 and is not read.
  - The sti_addr of word k is k. It is 0 for the first write and 1023 for the last.
- fg_count is 15 bits and holds 16384 exactly when every pixel is set; it never overflows.
- Border rows and columns are processed like all other pixels; no border forcing.
- start is ignored in READ and WRITE. thr changes after the start edge have no effect.
- Reset asserted mid-pass aborts immediately and all outputs return to reset values. Words already written stay in memory, and the next pass needs a new start.

## Timing
- The start edge enters READ, so the first res_addr=0 read is sampled on the following edge.
- Per word: 16 READ cycles + 1 WRITE cycle = 17 cycles.
- Full pass: 1024*17 = 17408 cycles from the start edge until the edge that raises done.
- sti_wr pulses exactly 1024 times per pass, never on consecutive cycles.
- sti_addr and sti_do are stable for the whole sti_wr cycle.
- res_rd is high in every READ cycle and low in WRITE, IDLE and DONE.
- fg_count is final on the edge that enters WRITE for word 1023, and it is stable while done=1.

## Test plan
- All-zero map, thr=1 -> 1024 writes of 16'h0000, sti_addr 0..1023 in order, fg_count=0, done exactly 17408 cycles after start.
- All-zero map, thr=0 -> every word 16'hFFFF, fg_count=16384.
- Map where res(y,x)=x, thr=120 -> words w=7 are 16'h00FF and all other words 16'h0000, fg_count=128*8=1024. This checks bit order and the x mapping.
- Single pixel res(5,17)=3 with all others 0, thr=3 -> one nonzero word at sti_addr=5*8+1=41 with value 16'h4000, fg_count=1.
- Pulse start again mid-pass, then reset at cycle 5000 -> the second start causes no change. After reset, all outputs read 0 and stay idle. A fresh start then gives a full correct pass.
- After done, change thr and pulse start -> done drops on the start edge, fg_count restarts from 0, and the new pass completes with results for the new threshold.

Source files
------------

// File: rtl/dt_pack.sv
// dt_pack: post-processing for the distance-transform datapath.
// Scans the 128x128 8-bit distance map once per pass and thresholds each pixel.
// Packs the 1-bit results MSB-first into 16-bit words for the binary image memory.
// Counts the set pixels of the pass.
module dt_pack (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start,
    input  logic [7:0]  i_thr,
    output logic        o_res_rd,
    output logic [13:0] o_res_addr,
    input  logic [7:0]  i_res_di,
    output logic        o_sti_wr,
    output logic [9:0]  o_sti_addr,
    output logic [15:0] o_sti_do,
    output logic [14:0] o_fg_count,
    output logic        o_busy,
    output logic        o_done
);

    typedef enum logic [1:0] {StIdle, StRead, StWrite, StDone} state_e;

    state_e      r_state;
    state_e      w_state_nxt;
    logic [7:0]  r_thr;
    logic [3:0]  r_bit;
    logic [15:0] r_shift;
    logic [13:0] r_res_addr;
    logic [9:0]  r_sti_addr;
    logic [14:0] r_fg_count;
    logic        w_pix;
    logic        w_accept;

    assign w_pix    = (i_res_di >= r_thr);
    assign w_accept = i_start && ((r_state == StIdle) || (r_state == StDone));

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: 16 READ cycles then one WRITE per word, DONE after word 1023.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            StIdle, StDone: begin
                if (i_start) begin
                    w_state_nxt = StRead;
                end
            end
            StRead: begin
                if (r_bit == 4'd15) begin
                    w_state_nxt = StWrite;
                end
            end
            StWrite: begin
                if (r_sti_addr == 10'd1023) begin
                    w_state_nxt = StDone;
                end else begin
                    w_state_nxt = StRead;
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    // Datapath: threshold latch, pixel shift/count, read address walk, word index capture.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_thr      <= 8'd0;
            r_bit      <= 4'd0;
            r_shift    <= 16'd0;
            r_res_addr <= 14'd0;
            r_sti_addr <= 10'd0;
            r_fg_count <= 15'd0;
        end else if (w_accept) begin
            r_thr      <= i_thr;
            r_bit      <= 4'd0;
            r_res_addr <= 14'd0;
            r_fg_count <= 15'd0;
        end else if (r_state == StRead) begin
            r_shift    <= {r_shift[14:0], w_pix};
            r_fg_count <= r_fg_count + 15'(w_pix);
            r_res_addr <= r_res_addr + 14'd1;
            r_bit      <= r_bit + 4'd1;
            // The last pixel of a word sits at res_addr[13:4] == word index.
            if (r_bit == 4'd15) begin
                r_sti_addr <= r_res_addr[13:4];
            end
        end
    end

    // Output decode from the current state and datapath registers.
    always_comb begin
        o_res_rd   = 1'b0;
        o_sti_wr   = 1'b0;
        o_busy     = 1'b0;
        o_done     = 1'b0;
        o_res_addr = r_res_addr;
        o_sti_addr = r_sti_addr;
        o_sti_do   = r_shift;
        o_fg_count = r_fg_count;
        unique case (r_state)
            StIdle:  ;
            StRead: begin
                o_res_rd = 1'b1;
                o_busy   = 1'b1;
            end
            StWrite: begin
                o_sti_wr = 1'b1;
                o_busy   = 1'b1;
            end
            StDone:  o_done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_dt_pack.sv
// Bench for dt_pack: models the distance RAM and the binary image memory.
// Reference results are computed pixel by pixel from the map and threshold.
module tb_dt_pack;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  thr;
    logic        res_rd;
    logic [13:0] res_addr;
    logic [7:0]  res_di;
    logic        sti_wr;
    logic [9:0]  sti_addr;
    logic [15:0] sti_do;
    logic [14:0] fg_count;
    logic        busy;
    logic        done;

    logic [7:0]  mem [16384];
    logic [15:0] sti_mem [1024];

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    int t0 = 0;
    int n_wr = 0;
    int consec_bad = 0;
    int rd_bad = 0;
    int addr_bad = 0;
    logic prev_wr = 1'b0;

    dt_pack dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_start    (start),
        .i_thr      (thr),
        .o_res_rd   (res_rd),
        .o_res_addr (res_addr),
        .i_res_di   (res_di),
        .o_sti_wr   (sti_wr),
        .o_sti_addr (sti_addr),
        .o_sti_do   (sti_do),
        .o_fg_count (fg_count),
        .o_busy     (busy),
        .o_done     (done)
    );

    assign res_di = mem[res_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Write-side monitor: captures words and checks write ordering/spacing.
    always @(negedge clk) begin
        if (rst_n && sti_wr) begin
            sti_mem[sti_addr] = sti_do;
            if (int'(sti_addr) != n_wr) addr_bad++;
            if (prev_wr) consec_bad++;
            if (res_rd) rd_bad++;
            n_wr++;
        end
        prev_wr = rst_n && sti_wr;
    end

    typedef struct {
        int          pat;       // 0 random, 1 res=x, 2 single pixel on low random background
        int          thr_v;
        int          exp_fg;    // -1: model only
        int          spot_addr; // -1: no spot check
        logic [15:0] spot_val;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    function automatic logic [15:0] model_word(input int k, input int t);
        logic [15:0] w;
        w = 16'h0000;
        for (int i = 0; i < 16; i++) begin
            if (int'(mem[k * 16 + i]) >= t) w[15 - i] = 1'b1;
        end
        return w;
    endfunction

    function automatic int model_fg(input int t);
        int c;
        c = 0;
        for (int p = 0; p < 16384; p++) begin
            if (int'(mem[p]) >= t) c++;
        end
        return c;
    endfunction

    // res_addr after n edges from the start edge: 16 pixels per 17-cycle word slot.
    function automatic int model_addr(input int n);
        return (16 * (n / 17) + (n % 17)) % 16384;
    endfunction

    task automatic fill_map(input int pat);
        for (int p = 0; p < 16384; p++) begin
            int x;
            int y;
            x = p % 128;
            y = p / 128;
            case (pat)
                1:       mem[p] = 8'(x);
                2:       mem[p] = (y == 5 && x == 17) ? 8'd3 : 8'($urandom_range(0, 2));
                default: mem[p] = 8'($urandom);
            endcase
        end
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_res_rd"}, int'(res_rd), 0);
        chk({tag, "_res_addr"}, int'(res_addr), 0);
        chk({tag, "_sti_wr"}, int'(sti_wr), 0);
        chk({tag, "_sti_addr"}, int'(sti_addr), 0);
        chk({tag, "_sti_do"}, int'(sti_do), 0);
        chk({tag, "_fg_count"}, int'(fg_count), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
    endtask

    // Pulses start with threshold t, then scrambles thr to show it is not re-sampled.
    task automatic start_pass(input int t);
        n_wr = 0;
        consec_bad = 0;
        rd_bad = 0;
        addr_bad = 0;
        for (int k = 0; k < 1024; k++) sti_mem[k] = 16'hDEAD;
        @(negedge clk);
        start = 1'b1;
        thr = 8'(t);
        @(posedge clk);
        #1;
        start = 1'b0;
        thr = ~8'(t);
        t0 = cyc;
        chk("start_busy", int'(busy), 1);
        chk("start_done", int'(done), 0);
        chk("start_res_rd", int'(res_rd), 1);
        chk("start_res_addr", int'(res_addr), 0);
        chk("start_fg", int'(fg_count), 0);
    endtask

    function automatic int word_mismatches(input int nwords, input int t);
        int bad;
        bad = 0;
        for (int k = 0; k < nwords; k++) begin
            if (sti_mem[k] !== model_word(k, t)) bad++;
        end
        return bad;
    endfunction

    task automatic finish_pass(input vec_t v);
        int  got_done;
        int  fg_exp;
        int  fg_seen;
        got_done = 0;
        for (int i = 0; i < 20000; i++) begin
            @(negedge clk);
            if (done) begin
                got_done = 1;
                break;
            end
        end
        chk("done_seen", got_done, 1);
        chk("pass_cycles", cyc - t0, 17408);
        chk("write_count", n_wr, 1024);
        chk("write_order", addr_bad, 0);
        chk("write_consecutive", consec_bad, 0);
        chk("res_rd_in_write", rd_bad, 0);
        chk("word_mismatches", word_mismatches(1024, v.thr_v), 0);
        fg_exp = model_fg(v.thr_v);
        chk("fg_model", int'(fg_count), fg_exp);
        if (v.exp_fg >= 0) chk("fg_table", int'(fg_count), v.exp_fg);
        if (v.spot_addr >= 0) chk("spot_word", int'(sti_mem[v.spot_addr]), int'(v.spot_val));
        fg_seen = int'(fg_count);
        repeat (3) @(negedge clk);
        chk("done_hold", int'(done), 1);
        chk("busy_after", int'(busy), 0);
        chk("res_rd_after", int'(res_rd), 0);
        chk("fg_stable", int'(fg_count), fg_seen);
    endtask

    initial begin
        vec_t vecs [4];
        int   thr_a;
        vecs[0] = '{pat: 0, thr_v: 255, exp_fg: -1,    spot_addr: -1, spot_val: 16'h0000};
        vecs[1] = '{pat: 0, thr_v: 0,   exp_fg: 16384, spot_addr: 100, spot_val: 16'hFFFF};
        vecs[2] = '{pat: 1, thr_v: 120, exp_fg: 1024,  spot_addr: 7,  spot_val: 16'h00FF};
        vecs[3] = '{pat: 2, thr_v: 3,   exp_fg: 1,     spot_addr: 41, spot_val: 16'h4000};

        rst_n = 1'b0;
        start = 1'b0;
        thr = 8'd0;
        fill_map(0);
        repeat (3) @(negedge clk);
        check_idle("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Aborted pass: ignored second start, then reset mid-pass.
        thr_a = int'($urandom_range(1, 254));
        start_pass(thr_a);
        while (cyc - t0 < 100) @(negedge clk);
        start = 1'b1;
        thr = 8'd0;
        @(posedge clk);
        #1;
        start = 1'b0;
        while (cyc - t0 < 103) @(negedge clk);
        chk("restart_ignored_addr", int'(res_addr), model_addr(cyc - t0));
        chk("restart_ignored_busy", int'(busy), 1);
        while (cyc - t0 < 5000) @(negedge clk);
        chk("abort_addr", int'(res_addr), model_addr(cyc - t0));
        rst_n = 1'b0;
        #1;
        check_idle("abort");
        chk("abort_words", n_wr, 294);
        chk("abort_word_data", word_mismatches(n_wr, thr_a), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check_idle("post_reset");

        // Back-to-back passes: each new start is issued from DONE with a new threshold.
        for (int i = 0; i < 4; i++) begin
            fill_map(vecs[i].pat);
            start_pass(vecs[i].thr_v);
            finish_pass(vecs[i]);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
